// File: rtl/survivor_tb_reader.sv
// rtl/survivor_tb_reader.sv - two-bank ping-pong survivor RAM, drained word BURST-1 down to 0
// Each write strobe fills one bank; the reader presents full banks in write order on a valid/ready port.
module survivor_tb_reader #(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                st,
  input  logic [BURST*DW-1:0] wr_data,
  output logic                wr_ready,
  output logic                overflow,
  output logic [DW-1:0]       out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
);

  localparam int IW = $clog2(BURST);
  localparam logic [IW-1:0] IDX_TOP = IW'(BURST - 1);

  typedef enum logic {IDLE, READ} state_t;

  state_t        state, state_next;
  logic [DW-1:0] ram [2*BURST];
  logic [1:0]    full;
  logic          wr_bank, rd_bank, rd_bank_next;
  logic [IW-1:0] rd_idx, rd_idx_next, idx_dec;
  logic [DW-1:0] out_data_next;
  logic          out_valid_next, out_last_next;
  logic          clear_full, handshake, wr_en;

  // Bank index is the MSB of the RAM address, so {bank, idx} addresses a word directly.
  assign wr_ready  = ~full[wr_bank];
  assign wr_en     = st & wr_ready;
  assign handshake = out_valid & out_ready;
  assign idx_dec   = rd_idx - 1'b1;

  always_comb begin
    state_next     = state;
    rd_idx_next    = rd_idx;
    rd_bank_next   = rd_bank;
    out_data_next  = out_data;
    out_valid_next = out_valid;
    out_last_next  = out_last;
    clear_full     = 1'b0;
    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          state_next     = READ;
          out_valid_next = 1'b1;
          rd_idx_next    = IDX_TOP;
          out_data_next  = ram[{rd_bank, IDX_TOP}];
          out_last_next  = 1'b0;
        end
      end
      READ: begin
        if (handshake) begin
          if (rd_idx != '0) begin
            rd_idx_next   = idx_dec;
            out_data_next = ram[{rd_bank, idx_dec}];
            out_last_next = (idx_dec == '0);
          end else begin
            clear_full    = 1'b1;
            rd_bank_next  = ~rd_bank;
            rd_idx_next   = IDX_TOP;
            out_last_next = 1'b0;
            // Only a bank full before this edge chains on without a bubble.
            if (full[~rd_bank]) begin
              out_data_next = ram[{~rd_bank, IDX_TOP}];
            end else begin
              state_next     = IDLE;
              out_valid_next = 1'b0;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2*BURST; i++) ram[i] <= '0;
      full      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      rd_idx    <= IDX_TOP;
      state     <= IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      rd_idx    <= rd_idx_next;
      rd_bank   <= rd_bank_next;
      out_data  <= out_data_next;
      out_valid <= out_valid_next;
      out_last  <= out_last_next;
      overflow  <= st & ~wr_ready;
      if (wr_en) begin
        for (int i = 0; i < BURST; i++) ram[{wr_bank, IW'(i)}] <= wr_data[i*DW +: DW];
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
      end
      // A write needs its bank empty and the reader clears a full bank, so the bits never collide.
      if (clear_full) full[rd_bank] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_survivor_tb_reader.sv
// tb/tb_survivor_tb_reader.sv - bench for survivor_tb_reader: queue-of-bursts model plus directed literal checks
module tb_survivor_tb_reader;

  localparam int DW = 8;
  localparam int BURST = 4;

  logic                clk = 1'b0;
  logic                rst, st, out_ready;
  logic [BURST*DW-1:0] wr_data;
  logic                wr_ready, overflow, out_valid, out_last;
  logic [DW-1:0]       out_data;

  survivor_tb_reader #(.DW(DW), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .st(st), .wr_data(wr_data), .wr_ready(wr_ready),
    .overflow(overflow), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit model_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: bursts held in a queue in write order; at most two can be buffered.
  logic [BURST*DW-1:0] bq[$];
  bit valid_m = 0;
  bit ovf_m = 0;
  int pos = BURST - 1;

  function automatic logic [DW-1:0] word_of(input logic [BURST*DW-1:0] b, input int p);
    return b[p*DW +: DW];
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      bq.delete();
      valid_m = 0;
      ovf_m = 0;
      pos = BURST - 1;
    end else begin
      automatic int n_full = bq.size();
      automatic bit hs = valid_m && out_ready;
      ovf_m = st && (n_full >= 2);
      if (hs) begin
        if (pos == 0) begin
          bq.delete(0);
          pos = BURST - 1;
          valid_m = (n_full >= 2);
        end else begin
          pos--;
        end
      end else if (!valid_m && n_full >= 1) begin
        valid_m = 1;
        pos = BURST - 1;
      end
      if (st && n_full < 2) bq.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (model_en) begin
      chk("m_out_valid", out_valid, valid_m);
      chk("m_wr_ready", wr_ready, bq.size() < 2);
      chk("m_overflow", overflow, ovf_m);
      if (valid_m && bq.size() > 0) begin
        chk("m_out_data", out_data, word_of(bq[0], pos));
        chk("m_out_last", out_last, pos == 0);
      end
    end
  end

  logic [DW:0] rec_d[$];
  int          rec_c[$];
  always @(negedge clk) begin
    if (out_valid && out_ready && !rst) begin
      rec_d.push_back({out_last, out_data});
      rec_c.push_back(cyc);
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic check_rec(input string name, input logic [DW:0] exp[$], input bit contiguous);
    chk({name, "_count"}, rec_d.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rec_d.size(); i++) begin
      chk($sformatf("%s_word%0d", name, i), rec_d[i], exp[i]);
      if (contiguous) chk($sformatf("%s_cycle%0d", name, i), rec_c[i] - rec_c[0], i);
    end
  endtask

  initial begin
    automatic logic [DW:0] exp[$];
    rst = 1; st = 0; out_ready = 0; wr_data = '0;
    step(2);

    // 1: reset state
    at_neg();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_out_data", out_data, 0);
    step(1);
    rst = 0;
    model_en = 1;

    // 2: single burst, one cycle latency, reverse order
    rec_d.delete(); rec_c.delete();
    out_ready = 1; st = 1; wr_data = {8'h44, 8'h33, 8'h22, 8'h11};
    step(1);
    st = 0;
    at_neg();
    chk("t2_valid_not_yet", out_valid, 0);
    step(1);
    at_neg();
    chk("t2_valid_rise", out_valid, 1);
    chk("t2_first_word", out_data, 8'h44);
    step(6);
    exp = '{9'h044, 9'h033, 9'h022, 9'h111};
    check_rec("t2", exp, 1);

    // 3: back-to-back bursts drain without a bubble
    rec_d.delete(); rec_c.delete();
    st = 1; wr_data = {8'h04, 8'h03, 8'h02, 8'h01};
    step(1);
    wr_data = {8'h08, 8'h07, 8'h06, 8'h05};
    step(1);
    st = 0;
    step(12);
    exp = '{9'h004, 9'h003, 9'h002, 9'h101, 9'h008, 9'h007, 9'h006, 9'h105};
    check_rec("t3", exp, 1);

    // 4: third burst dropped while both banks full
    rec_d.delete(); rec_c.delete();
    out_ready = 0; st = 1; wr_data = {8'h14, 8'h13, 8'h12, 8'h11};
    step(1);
    wr_data = {8'h24, 8'h23, 8'h22, 8'h21};
    step(1);
    at_neg();
    chk("t4_wr_ready_low", wr_ready, 0);
    wr_data = {8'h34, 8'h33, 8'h32, 8'h31};
    step(1);
    st = 0;
    at_neg();
    chk("t4_overflow_pulse", overflow, 1);
    step(1);
    at_neg();
    chk("t4_overflow_clear", overflow, 0);
    out_ready = 1;
    step(12);
    exp = '{9'h014, 9'h013, 9'h012, 9'h111, 9'h024, 9'h023, 9'h022, 9'h121};
    check_rec("t4", exp, 1);

    // 5: stall for three cycles while 0x33 is presented
    st = 1; wr_data = {8'h44, 8'h33, 8'h22, 8'h11};
    step(1);
    st = 0;
    step(2);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk($sformatf("t5_hold_data%0d", i), out_data, 8'h33);
      chk($sformatf("t5_hold_valid%0d", i), out_valid, 1);
      step(1);
    end
    out_ready = 1;
    step(1);
    at_neg();
    chk("t5_resume", out_data, 8'h22);
    step(4);

    // 6: reset mid-read, then a fresh burst
    st = 1; wr_data = {8'h44, 8'h33, 8'h22, 8'h11};
    step(1);
    st = 0;
    step(2);
    at_neg();
    chk("t6_pre_rst", out_data, 8'h33);
    rst = 1;
    step(1);
    at_neg();
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_wr_ready", wr_ready, 1);
    chk("t6_rst_data", out_data, 0);
    rst = 0;
    rec_d.delete(); rec_c.delete();
    st = 1; wr_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    step(1);
    st = 0;
    step(6);
    exp = '{9'h0A3, 9'h0A2, 9'h0A1, 9'h1A0};
    check_rec("t6", exp, 1);

    // Mixed strobe/back-pressure pattern, including drops on the freeing edge; model checks every cycle.
    for (int i = 0; i < 80; i++) begin
      st = (i % 3 == 0) || (i % 7 == 1);
      out_ready = (i % 5 != 0) && (i % 11 != 3);
      wr_data = {8'(i*4+3), 8'(i*4+2), 8'(i*4+1), 8'(i*4)};
      step(1);
    end
    st = 0; out_ready = 1;
    step(12);
    at_neg();
    chk("final_idle", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
